phase_timing_regfile: RTL and testbench
=======================================

Name: phase_timing_regfile

Overview:
- Parametrised successor to the traffic-light timing register bank. Holds NUM_PHASES programmable phase durations instead of fixed red/yellow/green.
- Each phase has two copies: a shadow copy written over the host bus and an active copy that drives the phase controller.
- Shadow values move to the active copy together, and only at a sequence boundary signalled by the controller. The running light sequence therefore never sees a partially updated set.
- Adds registered readback, a write lock, and error reporting.

Parameters:
- NUM_PHASES, 3: number of phase time registers.
- TIME_W, 4: width of each time value in ticks. Minimum 2.
- ADDR_W, 2: address width. Must satisfy 2^ADDR_W >= NUM_PHASES+1.
- RESET_TIME, 2: reset value of every shadow and active register. Must be non-zero.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe, single-cycle.
- rd_en  in  1  read strobe, single-cycle.
- addr  in  ADDR_W  0 = CTRL; 1..NUM_PHASES = phase (addr-1).
- wr_data  in  TIME_W  write data.
- cycle_done  in  1  one-cycle pulse from the phase controller at the end of a full phase sequence.
- phase_time  out  NUM_PHASES*TIME_W  active times; phase i is at [i*TIME_W +: TIME_W].
- rd_data  out  TIME_W  read data.
- rd_valid  out  1  read data qualifier.
- wr_err  out  1  one-cycle pulse on a rejected write.
- commit_pending  out  1  commit request outstanding.
- update_strobe  out  1  one-cycle pulse after the active set has been updated.

Behaviour:
- Reset (sampled on clk):
  - All shadow and active registers = RESET_TIME; lock = 0.
  - commit_pending, rd_valid, wr_err, update_strobe = 0; rd_data = 0.
  - Reset mid-operation discards any pending commit and any in-flight read.
- CTRL write (addr 0):
  - Always accepted, never errors, even when locked or pending.
  - lock <= wr_data[1].
  - wr_data[0]=1 sets commit_pending. wr_data[0]=0 leaves commit_pending unchanged; software cannot cancel a request.
- Phase write (addr 1..NUM_PHASES):
  - Accepted only if lock=0, commit_pending=0 and wr_data != 0. Then shadow[addr-1] <= wr_data at the clock edge.
  - Otherwise shadow is unchanged and wr_err = 1 on the following cycle.
- Write to addr > NUM_PHASES: ignored; wr_err = 1 next cycle.
- Commit:
  - At the edge where commit_pending=1 and cycle_done=1: every active[i] <= shadow[i] in the same cycle, and commit_pending <= 0.
  - update_strobe = 1 for exactly the following cycle.
  - cycle_done with commit_pending=0 has no effect.
  - A commit request written in the same cycle as cycle_done takes effect at the next cycle_done, not the current one.
  - lock does not block commit.
- Active outputs:
  - phase_time changes only on commit or reset.
  - Shadow writes never alter phase_time directly.
- Read:
  - Latency is 1 cycle. rd_en at edge N gives rd_valid=1 and rd_data valid during cycle N+1.
  - rd_data = 0 whenever rd_valid = 0.
  - addr 0 returns {zeros, lock, commit_pending} (bit1 = lock, bit0 = pending).
  - addr 1..NUM_PHASES returns the shadow value.
  - addr > NUM_PHASES returns 0 with rd_valid=1 and no error.
  - Back-to-back reads are supported every cycle.
- Simultaneous rd_en and wr_en to the same address: the read returns the pre-write value.
- Concurrent write and commit: a phase write cannot coincide with a commit, because commit_pending=1 blocks phase writes. The committed set is therefore always coherent.
- Widths: no arithmetic is performed. Values are stored verbatim; the zero check is the only value validation.

Test Plan:
- Reset, then read addrs 0..3: each rd_valid pulse 1 cycle after rd_en; data = 0,2,2,2; phase_time = {2,2,2}.
- Write phase1=5, phase2=3, phase3=9; phase_time stays {2,2,2}. Write CTRL=0x1: commit_pending=1. Pulse cycle_done: next cycle phase_time = {9,3,5} (phase3..phase1), update_strobe pulses once, commit_pending=0.
- With commit_pending=1, write phase1=7: wr_err pulses, read addr1 returns 5. Write phase2=0 after commit: wr_err pulses, shadow unchanged.
- Write CTRL=0x2 (lock): phase write rejected with wr_err; CTRL read returns 0x2. Write CTRL=0x3 then pulse cycle_done: commit still occurs. Write CTRL=0x0: lock released.
- CTRL=0x1 write coincident with cycle_done: no commit that cycle. Commit happens at the next cycle_done.
- Assert reset while commit_pending=1 and a read is in flight: rd_valid=0 next cycle, commit_pending=0, all times return to 2, and a later cycle_done causes no update_strobe.

Source files
------------

// File: rtl/phase_timing_regfile.sv
// Double-buffered phase duration register bank: host writes shadow copies,
// which move to the active set together only at a controller sequence boundary.
module phase_timing_regfile #(
  parameter int unsigned NUM_PHASES = 3,
  parameter int unsigned TIME_W     = 4,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned RESET_TIME = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [TIME_W-1:0]            wr_data,
  input  logic                         cycle_done,
  output logic [NUM_PHASES*TIME_W-1:0] phase_time,
  output logic [TIME_W-1:0]            rd_data,
  output logic                         rd_valid,
  output logic                         wr_err,
  output logic                         commit_pending,
  output logic                         update_strobe
);

  localparam int unsigned PT_W = NUM_PHASES * TIME_W;

  logic [TIME_W-1:0] shadow [NUM_PHASES];
  logic [PT_W-1:0]   active;
  logic              lock;

  logic              phase_hit_c;
  logic              wr_ok_c;
  logic [TIME_W-1:0] rd_mux_c;

  assign phase_time = active;

  // Address decode and readback mux; CTRL reads as {lock, commit_pending}
  always_comb begin
    phase_hit_c = 1'b0;
    rd_mux_c    = '0;
    wr_ok_c     = !lock && !commit_pending && (wr_data != '0);
    if (addr == '0) begin
      rd_mux_c = TIME_W'({lock, commit_pending});
    end
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if (addr == ADDR_W'(i + 1)) begin
        phase_hit_c = 1'b1;
        rd_mux_c    = shadow[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PHASES; i++) begin
        shadow[i] <= TIME_W'(RESET_TIME);
      end
      active         <= {NUM_PHASES{TIME_W'(RESET_TIME)}};
      lock           <= 1'b0;
      commit_pending <= 1'b0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
      wr_err         <= 1'b0;
      update_strobe  <= 1'b0;
    end else begin
      wr_err        <= 1'b0;
      update_strobe <= 1'b0;
      rd_valid      <= rd_en;
      rd_data       <= rd_en ? rd_mux_c : '0;

      // Commit uses the pending flag as it stood before this edge, so a
      // request written alongside cycle_done waits for the next boundary.
      if (commit_pending && cycle_done) begin
        for (int unsigned i = 0; i < NUM_PHASES; i++) begin
          active[i*TIME_W +: TIME_W] <= shadow[i];
        end
        commit_pending <= 1'b0;
        update_strobe  <= 1'b1;
      end

      if (wr_en) begin
        if (addr == '0) begin
          lock <= wr_data[1];
          if (wr_data[0]) begin
            commit_pending <= 1'b1;
          end
        end else if (phase_hit_c && wr_ok_c) begin
          for (int unsigned i = 0; i < NUM_PHASES; i++) begin
            if (addr == ADDR_W'(i + 1)) begin
              shadow[i] <= wr_data;
            end
          end
        end else begin
          wr_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_timing_regfile.sv
// Directed self-checking bench for phase_timing_regfile.
module tb_phase_timing_regfile;

  localparam int unsigned NUM_PHASES = 3;
  localparam int unsigned TIME_W     = 4;
  localparam int unsigned ADDR_W     = 2;

  logic                         clk;
  logic                         reset;
  logic                         wr_en;
  logic                         rd_en;
  logic [ADDR_W-1:0]            addr;
  logic [TIME_W-1:0]            wr_data;
  logic                         cycle_done;
  logic [NUM_PHASES*TIME_W-1:0] phase_time;
  logic [TIME_W-1:0]            rd_data;
  logic                         rd_valid;
  logic                         wr_err;
  logic                         commit_pending;
  logic                         update_strobe;

  int vectors;
  int miscompares;

  phase_timing_regfile #(
    .NUM_PHASES(NUM_PHASES),
    .TIME_W    (TIME_W),
    .ADDR_W    (ADDR_W),
    .RESET_TIME(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .addr          (addr),
    .wr_data       (wr_data),
    .cycle_done    (cycle_done),
    .phase_time    (phase_time),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .wr_err        (wr_err),
    .commit_pending(commit_pending),
    .update_strobe (update_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then drop the single-cycle strobes
  task automatic cyc();
    @(posedge clk);
    #1;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    cycle_done = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [TIME_W-1:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    cyc();
  endtask

  task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [TIME_W-1:0] exp);
    addr = a; rd_en = 1'b1;
    cyc();
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; cycle_done = 1'b0;
    addr = '0; wr_data = '0;
    cyc(); cyc();
    reset = 1'b0;

    chk("rst_phase_time", 32'(phase_time), 32'h222);
    chk("rst_pending", 32'(commit_pending), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_strobe", 32'(update_strobe), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);

    rd_chk("rd_ctrl0", 2'd0, 4'd0);
    rd_chk("rd_ph1", 2'd1, 4'd2);
    rd_chk("rd_ph2", 2'd2, 4'd2);
    rd_chk("rd_ph3", 2'd3, 4'd2);
    cyc();
    chk("idle_rd_valid", 32'(rd_valid), 32'd0);
    chk("idle_rd_data", 32'(rd_data), 32'd0);

    wr(2'd1, 4'd5);
    chk("wr_ph1_err", 32'(wr_err), 32'd0);
    wr(2'd2, 4'd3);
    wr(2'd3, 4'd9);
    chk("shadow_only", 32'(phase_time), 32'h222);
    wr(2'd0, 4'h1);
    chk("pending_set", 32'(commit_pending), 32'd1);

    wr(2'd1, 4'd7);
    chk("pending_block_err", 32'(wr_err), 32'd1);
    rd_chk("pending_block_rd", 2'd1, 4'd5);

    cycle_done = 1'b1;
    cyc();
    chk("commit_time", 32'(phase_time), 32'h935);
    chk("commit_strobe", 32'(update_strobe), 32'd1);
    chk("commit_clr", 32'(commit_pending), 32'd0);
    cyc();
    chk("strobe_once", 32'(update_strobe), 32'd0);

    wr(2'd2, 4'd0);
    chk("zero_err", 32'(wr_err), 32'd1);
    rd_chk("zero_rd", 2'd2, 4'd3);
    wr(2'd1, 4'd6);
    chk("wr_ph1b_err", 32'(wr_err), 32'd0);

    wr(2'd0, 4'h2);
    wr(2'd3, 4'd4);
    chk("lock_err", 32'(wr_err), 32'd1);
    rd_chk("lock_ctrl_rd", 2'd0, 4'h2);
    rd_chk("lock_ph3_rd", 2'd3, 4'd9);
    wr(2'd0, 4'h3);
    chk("lock_ctrl_err", 32'(wr_err), 32'd0);
    cycle_done = 1'b1;
    cyc();
    chk("lock_commit_time", 32'(phase_time), 32'h936);
    chk("lock_commit_strobe", 32'(update_strobe), 32'd1);
    wr(2'd0, 4'h0);
    rd_chk("unlock_ctrl_rd", 2'd0, 4'h0);
    wr(2'd1, 4'd8);
    chk("unlock_wr_err", 32'(wr_err), 32'd0);

    cycle_done = 1'b1;
    cyc();
    chk("idle_done_strobe", 32'(update_strobe), 32'd0);

    addr = 2'd0; wr_data = 4'h1; wr_en = 1'b1; cycle_done = 1'b1;
    cyc();
    chk("coincide_strobe", 32'(update_strobe), 32'd0);
    chk("coincide_pending", 32'(commit_pending), 32'd1);
    chk("coincide_time", 32'(phase_time), 32'h936);
    cycle_done = 1'b1;
    cyc();
    chk("late_commit_time", 32'(phase_time), 32'h938);
    chk("late_commit_strobe", 32'(update_strobe), 32'd1);

    addr = 2'd1; wr_data = 4'd4; wr_en = 1'b1; rd_en = 1'b1;
    cyc();
    chk("rw_same_old", 32'(rd_data), 32'd8);
    rd_chk("rw_same_new", 2'd1, 4'd4);

    wr(2'd0, 4'h1);
    chk("pre_rst_pending", 32'(commit_pending), 32'd1);
    addr = 2'd1; rd_en = 1'b1; reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    chk("midrst_pending", 32'(commit_pending), 32'd0);
    chk("midrst_time", 32'(phase_time), 32'h222);
    rd_chk("midrst_ph1", 2'd1, 4'd2);
    cycle_done = 1'b1;
    cyc();
    chk("midrst_no_strobe", 32'(update_strobe), 32'd0);
    chk("midrst_time_hold", 32'(phase_time), 32'h222);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
